fib_responder: RTL and testbench

Fixed-function responder for the `n`/`valid`/`done`/`result` Fibonacci request protocol. It is a hardwired alternative to the microcoded core, and any requester that drives this protocol can use either one. The block captures an index `n`, iterates the Fibonacci recurrence one step per cycle, and presents the 64-bit result. It holds the result under a four-phase handshake.

---
 rtl/fib_pkg.sv | 14 +
 rtl/fib_iter.sv | 49 ++++
 rtl/fib_responder.sv | 84 ++++++++
 tb/tb_fib_responder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared encodings and default widths for the hardwired Fibonacci responder.
package fib_pkg;

    localparam int FIB_N_W      = 8;
    localparam int FIB_R_W      = 64;
    localparam int FIB_MAX_N_64 = 93;

    typedef enum logic [1:0] {
        FIB_IDLE = 2'd0,
        FIB_CALC = 2'd1,
        FIB_DONE = 2'd2
    } fib_state_e;

endpackage

// File: rtl/fib_iter.sv
// Fibonacci recurrence datapath: a/b pair, down-counter and wrap tracking.
import fib_pkg::*;

module fib_iter #(
    parameter int N_W = FIB_N_W,
    parameter int R_W = FIB_R_W
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic           load,
    input  logic           step,
    input  logic [N_W-1:0] n,
    output logic [R_W-1:0] a,
    output logic           a_ovf,
    output logic           last
);

    logic [R_W-1:0] b;
    logic           b_ovf;
    logic [N_W-1:0] cnt;
    logic [R_W:0]   sum;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign last = (cnt == '0);

    // Overflow flags follow the pair so a sticky wrap survives the shift a<-b.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a     <= '0;
            b     <= '0;
            cnt   <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (load) begin
            a     <= '0;
            b     <= R_W'(1);
            cnt   <= n;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum[R_W-1:0];
            cnt   <= cnt - N_W'(1);
            a_ovf <= b_ovf;
            b_ovf <= a_ovf | b_ovf | sum[R_W];
        end
    end

endmodule

// File: rtl/fib_responder.sv
// Fixed-function responder for the n/valid/done/result Fibonacci protocol.
//   state    | meaning
//   FIB_IDLE | waiting for valid; captures n on the edge valid is seen
//   FIB_CALC | one recurrence step per cycle until the counter reaches 0
//   FIB_DONE | result held with done high until valid is seen low
import fib_pkg::*;

module fib_responder #(
    parameter int N_W = FIB_N_W,
    parameter int R_W = FIB_R_W
) (
    input  logic           clk,
    input  logic           aresetn,
    input  logic [N_W-1:0] n,
    input  logic           valid,
    output logic           done,
    output logic [R_W-1:0] result,
    output logic           overflow,
    output logic           busy
);

    fib_state_e     state, state_next;
    logic           load, step, capture;
    logic [R_W-1:0] a;
    logic           a_ovf, last;

    fib_iter #(.N_W(N_W), .R_W(R_W)) u_iter (
        .clk     (clk),
        .aresetn (aresetn),
        .load    (load),
        .step    (step),
        .n       (n),
        .a       (a),
        .a_ovf   (a_ovf),
        .last    (last)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        case (state)
            FIB_IDLE: begin
                if (valid) begin
                    load       = 1'b1;
                    state_next = FIB_CALC;
                end
            end
            FIB_CALC: begin
                if (last) begin
                    capture    = 1'b1;
                    state_next = FIB_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            FIB_DONE: begin
                if (!valid) state_next = FIB_IDLE;
            end
            default: state_next = FIB_IDLE;
        endcase
    end

    // done/busy are flopped from the next state so they line up with the transitions.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= FIB_IDLE;
            done     <= 1'b0;
            busy     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state_next == FIB_DONE);
            busy  <= (state_next != FIB_IDLE);
            if (capture) begin
                result   <= a;
                overflow <= a_ovf;
            end
        end
    end

endmodule

// File: tb/tb_fib_responder.sv
// Directed bench for fib_responder: hand-computed vectors plus a modular sweep.
import fib_pkg::*;

module tb_fib_responder;

    logic        clk;
    logic        aresetn;
    logic [7:0]  n;
    logic        valid;
    logic        done;
    logic [63:0] result;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_fails  = 0;

    fib_responder #(.N_W(8), .R_W(64)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .n        (n),
        .valid    (valid),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fib_ref(input int k);
        logic [63:0] x, y, t;
        x = 64'd0;
        y = 64'd1;
        for (int i = 0; i < k; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after a capture edge; returns the cycle count (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic [7:0] nv,
                           input logic [63:0] exp_res, input logic exp_ovf,
                           input bit full);
        int lat;
        n     = nv;
        valid = 1'b1;
        tick();
        if (full) begin
            check({tag, "_busy_rise"}, 64'(busy), 64'd1);
            check({tag, "_done_low"}, 64'(done), 64'd0);
        end
        wait_done(lat);
        check({tag, "_latency"}, 64'(lat), 64'(int'(nv) + 1));
        check({tag, "_result"}, result, exp_res);
        check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
        valid = 1'b0;
        tick();
        if (full) begin
            check({tag, "_done_fall"}, 64'(done), 64'd0);
            check({tag, "_busy_fall"}, 64'(busy), 64'd0);
            check({tag, "_result_hold"}, result, exp_res);
        end
    endtask

    initial begin
        int lat;
        aresetn = 1'b0;
        n       = 8'd0;
        valid   = 1'b0;
        tick();
        tick();
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        aresetn = 1'b1;
        tick();

        run_req("n10", 8'd10, 64'd55, 1'b0, 1'b1);
        run_req("n0", 8'd0, 64'd0, 1'b0, 1'b1);
        run_req("n1", 8'd1, 64'd1, 1'b0, 1'b1);
        run_req("n93", 8'd93, 64'd12200160415121876738, 1'b0, 1'b1);
        run_req("n94", 8'd94, 64'd1293530146158671551, 1'b1, 1'b1);

        // valid dropped and n changed mid-CALC: request still completes with captured n
        n     = 8'd20;
        valid = 1'b1;
        tick();
        tick();
        tick();
        tick();
        valid = 1'b0;
        n     = 8'd5;
        for (int c = 4; c <= 400; c++) begin
            tick();
            if (done) begin
                lat = c;
                break;
            end
            lat = 0;
        end
        check("drop_latency", 64'(lat), 64'd21);
        check("drop_result", result, 64'd6765);
        check("drop_overflow", 64'(overflow), 64'd0);
        tick();
        check("drop_done_1cyc", 64'(done), 64'd0);
        tick();
        check("drop_no_rerun", 64'(busy), 64'd0);

        // async reset mid-CALC clears outputs without waiting for an edge
        n     = 8'd50;
        valid = 1'b1;
        tick();
        for (int c = 0; c < 10; c++) tick();
        check("abort_busy_before", 64'(busy), 64'd1);
        aresetn = 1'b0;
        #1;
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", result, 64'd0);
        check("abort_overflow", 64'(overflow), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        valid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        run_req("after_abort_n7", 8'd7, 64'd13, 1'b0, 1'b1);

        for (int i = 1; i <= 254; i++) begin
            run_req($sformatf("sweep_n%0d", i), 8'(i), fib_ref(i),
                    (i > FIB_MAX_N_64), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
